// File: rtl/pc_tx.sv
// pc_tx: byte FIFO from the DataManager feeding an 8N1 UART serializer toward the FTDI RXD pin.
// Latency: a push into an empty, idle block puts the start bit on the line two clocks later.
// Backpressure: none toward the writer; a push while full is dropped and latches o_overflow_sig.
//
// Ports:
//   i_clock, i_reset                       clock and synchronous active-high reset
//   i_write_next_byte_cmd, i_tx_byte       one-cycle write strobe and its byte
//   o_fifo_is_full_sig, o_fifo_is_empty_sig, o_overflow_sig   FIFO status (overflow is sticky)
//   o_tx_serial, o_tx_active, o_tx_done    UART line, frame-in-progress, end-of-stop pulse
module pc_tx #(
    parameter int CLKS_PER_BIT = 435,
    parameter int FIFO_ADDR_W  = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_write_next_byte_cmd,
    input  logic [7:0] i_tx_byte,
    output logic       o_fifo_is_full_sig,
    output logic       o_fifo_is_empty_sig,
    output logic       o_overflow_sig,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]             mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr;
    logic [FIFO_ADDR_W-1:0] rd_ptr;
    logic [FIFO_ADDR_W:0]   count;
    logic [FIFO_ADDR_W:0]   count_next;
    logic                   push;
    logic                   pop;

    logic [1:0]             state;
    logic [CNT_W-1:0]       clk_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_reg;
    logic                   bit_end;

    // A full FIFO refuses the write even if the serializer pops in the same cycle.
    assign push    = i_write_next_byte_cmd && !o_fifo_is_full_sig;
    assign pop     = (state == S_IDLE) && !o_fifo_is_empty_sig;
    assign bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage carries no reset; contents are only meaningful through the pointers.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= i_tx_byte;
        end
    end

    // Status flags are registered from the next count so they track count exactly.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            o_fifo_is_full_sig  <= 1'b0;
            o_fifo_is_empty_sig <= 1'b1;
            o_overflow_sig      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (i_write_next_byte_cmd && o_fifo_is_full_sig) begin
                o_overflow_sig <= 1'b1;
            end
            count               <= count_next;
            o_fifo_is_full_sig  <= (count_next == (FIFO_ADDR_W+1)'(DEPTH));
            o_fifo_is_empty_sig <= (count_next == '0);
        end
    end

    // The line value is registered one state ahead: each transition loads the level
    // the next state drives, so the line moves on the same clock the state does.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_tx_serial <= 1'b1;
                    o_tx_active <= 1'b0;
                    if (pop) begin
                        shift_reg   <= mem[rd_ptr];
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        o_tx_serial <= 1'b0;
                        o_tx_active <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        o_tx_serial <= shift_reg[0];
                        state       <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_tx_serial <= 1'b1;
                            state       <= S_STOP;
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            o_tx_serial <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin // S_STOP
                    // Registered pulse: armed one clock early so it lands on the last stop clock.
                    if (clk_cnt == CNT_W'(CLKS_PER_BIT - 2)) begin
                        o_tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        o_tx_active <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_tx.sv
// tb_pc_tx: scoreboard bench for pc_tx; pushed bytes queue up and a line monitor decodes frames.
// Latency: none (bench).
// Backpressure: none (bench).
module tb_pc_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       wr;
    logic [7:0] tx_byte;
    logic       full, empty, ovf, serial, active, done;

    logic       def_wr;
    logic [7:0] def_byte;
    logic       def_full, def_empty, def_ovf, def_serial, def_active, def_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames_done = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    bit         mon_busy = 0;
    int         mon_pos = 0;
    logic [7:0] mon_byte = 8'h00;

    pc_tx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(2)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_write_next_byte_cmd(wr), .i_tx_byte(tx_byte),
        .o_fifo_is_full_sig(full), .o_fifo_is_empty_sig(empty), .o_overflow_sig(ovf),
        .o_tx_serial(serial), .o_tx_active(active), .o_tx_done(done)
    );

    pc_tx dut_def (
        .i_clock(clk), .i_reset(rst),
        .i_write_next_byte_cmd(def_wr), .i_tx_byte(def_byte),
        .o_fifo_is_full_sig(def_full), .o_fifo_is_empty_sig(def_empty), .o_overflow_sig(def_ovf),
        .o_tx_serial(def_serial), .o_tx_active(def_active), .o_tx_done(def_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: every clock is checked against the frame expected from the scoreboard head.
    always @(negedge clk) begin
        int  bit_i;
        logic exp_line;
        logic exp_done;
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            last_done_cyc = cyc;
        end
        if (rst) begin
            mon_busy = 0;
            mon_pos  = 0;
        end else begin
            if (!mon_busy && serial === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame cyc=%0d: line fell with nothing queued", cyc);
                    mon_byte = 8'h00;
                end else begin
                    mon_byte = exp_q.pop_front();
                end
                start_q.push_back(cyc);
                mon_busy = 1;
                mon_pos  = 0;
            end
            if (mon_busy) begin
                bit_i    = mon_pos / CPB;
                exp_line = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : mon_byte[bit_i-1];
                exp_done = (mon_pos == FRAME - 1);
                checks++;
                if (serial !== exp_line || done !== exp_done || active !== 1'b1) begin
                    failures++;
                    $display("FAIL frame_bit cyc=%0d byte=%02h pos=%0d: got line=%b done=%b active=%b, need line=%b done=%b active=1",
                             cyc, mon_byte, mon_pos, serial, done, active, exp_line, exp_done);
                end
                mon_pos++;
                if (mon_pos == FRAME) begin
                    mon_busy = 0;
                    frames_done++;
                end
            end else begin
                checks++;
                if (serial !== 1'b1 || done !== 1'b0 || active !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_line cyc=%0d: got line=%b done=%b active=%b, need 1/0/0",
                             cyc, serial, done, active);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr = 1'b0;
        def_wr = 1'b0;
        repeat (3) step();
        exp_q.delete();
        start_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (frames_done < target) begin
            failures++;
            $display("FAIL frame_timeout: got %0d frames, need %0d", frames_done, target);
        end
    endtask

    task automatic test_reset();
        int lows = 0;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({serial, empty, full, active, ovf, done} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_values: got serial,empty,full,active,ovf,done=%b, need 110000",
                     {serial, empty, full, active, ovf, done});
        end
        rst = 1'b0;
        repeat (100) begin
            step();
            if (serial !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL reset_idle_line: got %0d non-high cycles, need 0", lows);
        end
    endtask

    task automatic test_single();
        int push_cyc;
        int f0;
        int d0;
        do_reset();
        f0 = frames_done;
        d0 = done_cnt;
        wr = 1'b1;
        tx_byte = 8'hA5;
        push_cyc = cyc;
        exp_q.push_back(8'hA5);
        step();
        wr = 1'b0;
        checks++;
        if (empty !== 1'b0) begin
            failures++;
            $display("FAIL single_empty_n1: got %b, need 0", empty);
        end
        step();
        checks++;
        if (empty !== 1'b1 || serial !== 1'b0) begin
            failures++;
            $display("FAIL single_n2: got empty=%b line=%b, need empty=1 line=0", empty, serial);
        end
        wait_frames(f0 + 1, 100);
        checks++;
        if (start_q.size() != 1 || start_q[0] - push_cyc != 2) begin
            failures++;
            $display("FAIL single_latency: got %0d starts, first at +%0d, need 1 at +2",
                     start_q.size(), (start_q.size() > 0) ? start_q[0] - push_cyc : -1);
        end
        checks++;
        if (done_cnt - d0 != 1 || last_done_cyc - push_cyc != 41) begin
            failures++;
            $display("FAIL single_done: got %0d pulses last at +%0d, need 1 at +41",
                     done_cnt - d0, last_done_cyc - push_cyc);
        end
        checks++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_drain: got empty=%b queued=%0d, need 1 and 0", empty, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int f0;
        int d0;
        bytes = '{8'h00, 8'hFF, 8'h55};
        do_reset();
        f0 = frames_done;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1;
            tx_byte = bytes[i];
            exp_q.push_back(bytes[i]);
            step();
        end
        wr = 1'b0;
        wait_frames(f0 + 3, 200);
        checks++;
        if (start_q.size() != 3 || start_q[1] - start_q[0] != FRAME + 1 || start_q[2] - start_q[1] != FRAME + 1) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d starts, need 3 spaced %0d apart", start_q.size(), FRAME + 1);
        end
        checks++;
        if (done_cnt - d0 != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_done: got %0d pulses queued=%0d, need 3 and 0", done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int f0;
        do_reset();
        f0 = frames_done;
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1;
            tx_byte = 8'(i + 1);
            if (i < 5) exp_q.push_back(8'(i + 1));
            step();
            if (i == 3) begin
                checks++;
                if (full !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_not_full_yet: got full=%b, need 0", full);
                end
            end
            if (i == 4) begin
                checks++;
                if (full !== 1'b1 || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_full: got full=%b ovf=%b, need 1 and 0", full, ovf);
                end
            end
        end
        wr = 1'b0;
        checks++;
        if (ovf !== 1'b1 || full !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got ovf=%b full=%b, need 1 and 1", ovf, full);
        end
        wait_frames(f0 + 5, 300);
        repeat (10) step();
        checks++;
        if (ovf !== 1'b1 || empty !== 1'b1 || exp_q.size() != 0 || frames_done - f0 != 5) begin
            failures++;
            $display("FAIL ovf_drain: got ovf=%b empty=%b queued=%0d frames=%0d, need 1 1 0 5",
                     ovf, empty, exp_q.size(), frames_done - f0);
        end
    endtask

    task automatic test_simul_push_pop();
        int f0;
        int n = 0;
        do_reset();
        f0 = frames_done;
        wr = 1'b1; tx_byte = 8'h3C; exp_q.push_back(8'h3C); step();
        wr = 1'b1; tx_byte = 8'hC3; exp_q.push_back(8'hC3); step();
        wr = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL simul_wait_done: got done=%b, need 1", done);
        end
        step();
        // Idle clock: the serializer pops the queued byte while this one arrives.
        wr = 1'b1; tx_byte = 8'h96; exp_q.push_back(8'h96); step();
        wr = 1'b0;
        checks++;
        if (empty !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL simul_count: got empty=%b full=%b, need 0 and 0", empty, full);
        end
        wait_frames(f0 + 3, 200);
        checks++;
        if (start_q.size() != 3 || start_q[2] - start_q[1] != FRAME + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL simul_order: got %0d starts queued=%0d, need 3 and 0", start_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        int d0;
        int n = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1;
            tx_byte = (i == 0) ? 8'h0F : 8'(8'h11 * i);
            exp_q.push_back(tx_byte);
            step();
        end
        wr = 1'b0;
        while (!(mon_busy && mon_pos >= 4 * CPB + 1) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (!(mon_busy && mon_pos >= 4 * CPB + 1 && mon_pos < 5 * CPB)) begin
            failures++;
            $display("FAIL mid_position: got busy=%0d pos=%0d, need inside data bit 3", mon_busy, mon_pos);
        end
        f0 = frames_done;
        d0 = done_cnt;
        rst = 1'b1;
        step();
        checks++;
        if (serial !== 1'b1 || active !== 1'b0 || empty !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got line=%b active=%b empty=%b done=%b, need 1 0 1 0",
                     serial, active, empty, done);
        end
        step();
        rst = 1'b0;
        exp_q.delete();
        repeat (100) step();
        checks++;
        if (frames_done != f0 || done_cnt != d0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL mid_after: got frames+%0d done+%0d empty=%b, need 0 0 1",
                     frames_done - f0, done_cnt - d0, empty);
        end
    endtask

    task automatic test_default_params();
        int push_cyc;
        int t_start;
        int n = 0;
        do_reset();
        def_wr = 1'b1;
        def_byte = 8'h41;
        push_cyc = cyc;
        step();
        def_wr = 1'b0;
        while (def_serial !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        t_start = cyc;
        checks++;
        if (t_start - push_cyc != 2) begin
            failures++;
            $display("FAIL def_latency: got start at +%0d, need +2", t_start - push_cyc);
        end
        n = 0;
        while (def_serial === 1'b0 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (n != 435) begin
            failures++;
            $display("FAIL def_start_bit: got %0d clocks low, need 435", n);
        end
        n = 0;
        while (def_done !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        checks++;
        if (def_done !== 1'b1 || cyc - t_start + 1 != 4350) begin
            failures++;
            $display("FAIL def_frame_len: got done=%b after %0d clocks, need 1 after 4350",
                     def_done, cyc - t_start + 1);
        end
        step();
        checks++;
        if (def_serial !== 1'b1 || def_active !== 1'b0 || def_empty !== 1'b1 || def_ovf !== 1'b0 || def_full !== 1'b0) begin
            failures++;
            $display("FAIL def_idle: got line=%b active=%b empty=%b ovf=%b full=%b, need 1 0 1 0 0",
                     def_serial, def_active, def_empty, def_ovf, def_full);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr = 1'b0;
        tx_byte = 8'h00;
        def_wr = 1'b0;
        def_byte = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simul_push_pop();
        test_reset_mid();
        test_default_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
